// File: rtl/gerador_passos_equilibrio.sv
// Step-command source for the balance position counter: debounced player buttons plus a
// periodic gravity drift, merged into single-cycle conta/count_up strobes with loss detection.
module gerador_passos_equilibrio #(
  parameter int unsigned M           = 100,
  parameter int unsigned N           = 7,
  parameter int unsigned DEB_CICLOS  = 50000,
  parameter int unsigned TICK_PASSO  = 500000,
  parameter int unsigned TICK_DERIVA = 2000000
) (
  input  logic         clock,
  input  logic         zera_as_n,
  input  logic         habilita,
  input  logic         botao_esq,
  input  logic         botao_dir,
  input  logic [N-1:0] posicao,
  input  logic         fim,
  input  logic         inicio,
  output logic         conta,
  output logic         count_up,
  output logic         perdeu,
  output logic [1:0]   estado
);

  localparam int unsigned DW = $clog2(DEB_CICLOS + 1);
  localparam int unsigned PW = $clog2(TICK_PASSO + 1);
  localparam int unsigned TW = $clog2(TICK_DERIVA + 1);
  localparam logic [N-1:0] MID = N'(M / 2);

  typedef enum logic [1:0] {
    StOcioso = 2'b00,
    StAtivo  = 2'b01,
    StPerdeu = 2'b10
  } estado_e;

  // Request encoding: bit0 = up (dir only), bit1 = down (esq only).
  localparam logic [1:0] ReqNone = 2'b00;

  estado_e           estado_q, estado_d;
  logic [1:0]        sync1_q, sync2_q;
  logic [1:0]        nivel_q, nivel_d;
  logic [1:0][DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]        req, req_ant_q, req_ant_d;
  logic [PW-1:0]     rep_q, rep_d;
  logic [TW-1:0]     der_q, der_d;
  logic              conta_q, conta_d;
  logic              up_q, up_d;
  logic              p_step, d_step, d_up, step, step_up;

  // Debouncer: accept a new level only after DEB_CICLOS consecutive differing cycles.
  always_comb begin
    nivel_d   = nivel_q;
    deb_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != nivel_q[i]) begin
        if (deb_cnt_q[i] == DW'(DEB_CICLOS - 1)) begin
          nivel_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign req = {nivel_q[0] & ~nivel_q[1], nivel_q[1] & ~nivel_q[0]};

  always_comb begin
    estado_d  = estado_q;
    req_ant_d = ReqNone;
    rep_d     = '0;
    der_d     = '0;
    conta_d   = 1'b0;
    up_d      = 1'b0;
    p_step    = 1'b0;
    d_step    = 1'b0;
    d_up      = (posicao >= MID);
    step      = 1'b0;
    step_up   = 1'b0;

    unique case (estado_q)
      StOcioso: begin
        if (habilita) estado_d = StAtivo;
      end
      StAtivo: begin
        req_ant_d = req;
        if (req != req_ant_q) begin
          p_step = (req != ReqNone);
        end else if (req != ReqNone) begin
          if (rep_q == PW'(TICK_PASSO - 1)) begin
            p_step = 1'b1;
          end else begin
            rep_d = rep_q + 1'b1;
          end
        end

        if (der_q == TW'(TICK_DERIVA - 1)) begin
          d_step = 1'b1;
        end else begin
          der_d = der_q + 1'b1;
        end

        // Opposite player and drift steps in the same cycle cancel out.
        if (p_step && d_step) begin
          step    = (req[0] == d_up);
          step_up = d_up;
        end else if (p_step) begin
          step    = 1'b1;
          step_up = req[0];
        end else if (d_step) begin
          step    = 1'b1;
          step_up = d_up;
        end

        if (step) begin
          if (step_up ? fim : inicio) begin
            estado_d = StPerdeu;
          end else begin
            conta_d = 1'b1;
            up_d    = step_up;
          end
        end
      end
      StPerdeu: begin
      end
      default: estado_d = StOcioso;
    endcase

    if (!habilita) begin
      estado_d  = StOcioso;
      conta_d   = 1'b0;
      up_d      = 1'b0;
      rep_d     = '0;
      der_d     = '0;
      req_ant_d = ReqNone;
    end
  end

  always_ff @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n) begin
      estado_q  <= StOcioso;
      sync1_q   <= '0;
      sync2_q   <= '0;
      nivel_q   <= '0;
      deb_cnt_q <= '0;
      req_ant_q <= ReqNone;
      rep_q     <= '0;
      der_q     <= '0;
      conta_q   <= 1'b0;
      up_q      <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      sync1_q   <= {botao_dir, botao_esq};
      sync2_q   <= sync1_q;
      nivel_q   <= nivel_d;
      deb_cnt_q <= deb_cnt_d;
      req_ant_q <= req_ant_d;
      rep_q     <= rep_d;
      der_q     <= der_d;
      conta_q   <= conta_d;
      up_q      <= up_d;
    end
  end

  assign conta    = conta_q;
  assign count_up = up_q;
  assign perdeu   = (estado_q == StPerdeu);
  assign estado   = estado_q;

endmodule

// File: tb/tb_gerador_passos_equilibrio.sv
// Directed bench for gerador_passos_equilibrio with a behavioural up/down counter
// closing the loop on posicao/fim/inicio.
module tb_gerador_passos_equilibrio;

  localparam int unsigned M = 10;
  localparam int unsigned N = 4;

  logic         clk;
  logic         rst_n;
  logic         hab;
  logic         esq;
  logic         dir;
  logic [N-1:0] pos;
  logic         fim;
  logic         inicio;
  logic         conta;
  logic         count_up;
  logic         perdeu;
  logic [1:0]   estado;
  logic         ld;
  logic [N-1:0] ld_val;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt;

  gerador_passos_equilibrio #(
    .M(M), .N(N), .DEB_CICLOS(4), .TICK_PASSO(10), .TICK_DERIVA(20)
  ) dut (
    .clock    (clk),
    .zera_as_n(rst_n),
    .habilita (hab),
    .botao_esq(esq),
    .botao_dir(dir),
    .posicao  (pos),
    .fim      (fim),
    .inicio   (inicio),
    .conta    (conta),
    .count_up (count_up),
    .perdeu   (perdeu),
    .estado   (estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter model: consumes conta on the following edge.
  always @(posedge clk) begin
    if (ld) pos <= ld_val;
    else if (conta) pos <= count_up ? pos + 4'd1 : pos - 4'd1;
  end
  assign fim    = (pos == N'(M - 1));
  assign inicio = (pos == '0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic win(input int n, output int c);
    c = 0;
    repeat (n) begin
      tick();
      if (conta === 1'b1) c++;
    end
  endtask

  initial begin
    rst_n = 1'b1; hab = 1'b0; esq = 1'b0; dir = 1'b0; ld = 1'b1; ld_val = 4'd5;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_conta", conta, 0);
    chk("rst_count_up", count_up, 0);
    chk("rst_perdeu", perdeu, 0);
    chk("rst_estado", estado, 0);
    tick(); tick();
    rst_n = 1'b1; ld = 1'b0;

    // Bounce while enabled: only drift may step, and not before 20 cycles.
    hab = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      dir = (i < 16) && ((i % 4) < 2);
      tick();
      if (i == 0) chk("ativo_entry", estado, 1);
      if (conta === 1'b1) cnt++;
    end
    chk("bounce_no_conta", cnt, 0);
    tick();
    chk("drift_up_conta", conta, 1);
    chk("drift_up_dir", count_up, 1);
    ld = 1'b1; ld_val = 4'd4;
    tick();
    ld = 1'b0;
    chk("drift_single", conta, 0);
    win(18, cnt);
    chk("drift_gap", cnt, 0);
    tick();
    chk("drift_down_conta", conta, 1);
    chk("drift_down_dir", count_up, 0);
    hab = 1'b0;
    tick();
    chk("disable_idle", estado, 0);
    repeat (3) tick();

    // Press and hold dir, then release.
    ld = 1'b1; ld_val = 4'd5; hab = 1'b1; dir = 1'b1;
    tick();
    ld = 1'b0;
    win(5, cnt);
    chk("press_early", cnt, 0);
    tick();
    chk("press_first_conta", conta, 1);
    chk("press_first_dir", count_up, 1);
    win(9, cnt);
    chk("repeat_gap", cnt, 0);
    tick();
    chk("press_repeat_conta", conta, 1);
    chk("press_repeat_dir", count_up, 1);
    dir = 1'b0;
    win(3, cnt);
    chk("release_gap", cnt, 0);
    tick();
    chk("drift_at_pos7", conta, 1);
    chk("drift_at_pos7_dir", count_up, 1);
    win(10, cnt);
    chk("release_no_step", cnt, 0);
    hab = 1'b0;
    repeat (4) tick();

    // Player up coincides with drift down: cancel.
    ld = 1'b1; ld_val = 4'd3; hab = 1'b1;
    tick();
    ld = 1'b0;
    repeat (13) tick();
    dir = 1'b1;
    win(6, cnt);
    chk("cancel_pre", cnt, 0);
    tick();
    chk("cancel_opposite", conta, 0);
    win(9, cnt);
    chk("cancel_gap", cnt, 0);
    tick();
    chk("after_cancel_conta", conta, 1);
    chk("after_cancel_dir", count_up, 1);
    dir = 1'b0; hab = 1'b0;
    repeat (9) tick();

    // Player up coincides with drift up: exactly one step.
    ld = 1'b1; ld_val = 4'd6; hab = 1'b1;
    tick();
    ld = 1'b0;
    repeat (13) tick();
    dir = 1'b1;
    win(6, cnt);
    chk("same_pre", cnt, 0);
    tick();
    chk("same_conta", conta, 1);
    chk("same_dir", count_up, 1);
    tick();
    chk("same_single", conta, 0);
    dir = 1'b0; hab = 1'b0;
    repeat (9) tick();

    // Loss on up step at fim.
    ld = 1'b1; ld_val = 4'd9; hab = 1'b1;
    tick();
    ld = 1'b0;
    win(19, cnt);
    chk("loss_pre", cnt, 0);
    chk("loss_pre_estado", estado, 1);
    tick();
    chk("loss_up_conta", conta, 0);
    chk("loss_up_estado", estado, 2);
    chk("loss_up_perdeu", perdeu, 1);
    dir = 1'b1;
    win(15, cnt);
    chk("lost_ignores_buttons", cnt, 0);
    chk("lost_sticky", estado, 2);
    hab = 1'b0;
    tick();
    chk("lost_clear_estado", estado, 0);
    chk("lost_clear_perdeu", perdeu, 0);
    dir = 1'b0;
    repeat (8) tick();

    // Loss on down step at inicio.
    ld = 1'b1; ld_val = 4'd0; hab = 1'b1;
    tick();
    ld = 1'b0;
    win(19, cnt);
    chk("loss_down_pre", cnt, 0);
    tick();
    chk("loss_down_conta", conta, 0);
    chk("loss_down_estado", estado, 2);
    hab = 1'b0;
    repeat (4) tick();

    // Asynchronous reset during an active strobe.
    ld = 1'b1; ld_val = 4'd5; hab = 1'b1; dir = 1'b1;
    tick();
    ld = 1'b0;
    win(5, cnt);
    tick();
    chk("pre_reset_conta", conta, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_conta", conta, 0);
    chk("async_rst_count_up", count_up, 0);
    chk("async_rst_estado", estado, 0);
    chk("async_rst_perdeu", perdeu, 0);
    tick();
    rst_n = 1'b1;
    tick();
    win(5, cnt);
    chk("reset_fresh_debounce", cnt, 0);
    tick();
    chk("post_reset_conta", conta, 1);
    chk("post_reset_dir", count_up, 1);
    dir = 1'b0; hab = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
